control_mult_div: RTL and testbench

- Sequencer and arbiter for the EX-stage iterative multiply/divide unit. It owns the HI/LO registers.
- Accepts MULT/MULTU/DIV/DIVU from the ID/EX register and runs 32 shift-add or restoring iterations.
- Stalls the pipeline while the unit is busy and a dependent instruction (MFHI/MFLO or a new mult/div) arrives.
- Drives the EX result mux select so MFHI/MFLO take HI or LO instead of the ALU result.

---
 rtl/control_mult_div_if.sv | 28 ++
 rtl/control_mult_div.sv | 169 ++++++++++++++++
 tb/tb_control_mult_div.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/control_mult_div_if.sv
// Handshake/data bundle between the ID/EX stage (master) and the EX-stage mult/div sequencer (slave).
interface control_mult_div_if #(
  parameter int unsigned ANCHO = 32
);
  logic             inicio;
  logic [1:0]       op;
  logic [ANCHO-1:0] operando_a;
  logic [ANCHO-1:0] operando_b;
  logic             lee_hilo;
  logic             sel_hilo;
  logic             ocupado;
  logic             stall;
  logic             listo;
  logic             sel_salida;
  logic [ANCHO-1:0] hilo_dato;
  logic [ANCHO-1:0] hi;
  logic [ANCHO-1:0] lo;

  modport master (
    output inicio, op, operando_a, operando_b, lee_hilo, sel_hilo,
    input  ocupado, stall, listo, sel_salida, hilo_dato, hi, lo
  );

  modport slave (
    input  inicio, op, operando_a, operando_b, lee_hilo, sel_hilo,
    output ocupado, stall, listo, sel_salida, hilo_dato, hi, lo
  );
endinterface

// File: rtl/control_mult_div.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO, with pipeline stall and EX result select.
// Define MULT_DIV_DIVISION_EN to build the restoring divider; otherwise DIV/DIVU starts are ignored.
module control_mult_div #(
  parameter int unsigned ANCHO = 32,
  parameter int unsigned ITER  = 32
) (
  input  logic              clk,
  input  logic              reset,
  control_mult_div_if.slave bus
);
  localparam int unsigned   CW       = $clog2(ITER);
  localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);

  typedef enum logic [1:0] { IDLE, CALC, FIN } estado_t;

  estado_t            state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*ANCHO-1:0] acc_q, acc_d;
  logic [ANCHO-1:0]   mag_b_q, mag_b_d;
  logic               neg_q, neg_d;
  logic               ocupado_q, ocupado_d;
  logic               listo_q, listo_d;
  logic [ANCHO-1:0]   hi_q, hi_d;
  logic [ANCHO-1:0]   lo_q, lo_d;

  logic               signo_a, signo_b, acepta;
  logic [ANCHO-1:0]   mag_a, mag_b;
  logic [ANCHO:0]     suma;
  logic [2*ANCHO-1:0] paso_mul, producto;

  assign signo_a = bus.op[0] & bus.operando_a[ANCHO-1];
  assign signo_b = bus.op[0] & bus.operando_b[ANCHO-1];
  assign mag_a   = signo_a ? -bus.operando_a : bus.operando_a;
  assign mag_b   = signo_b ? -bus.operando_b : bus.operando_b;

  // acc holds {partial product, remaining multiplier bits}; each step adds and shifts right.
  assign suma     = {1'b0, acc_q[2*ANCHO-1:ANCHO]} + (acc_q[0] ? {1'b0, mag_b_q} : '0);
  assign paso_mul = {suma, acc_q[ANCHO-1:1]};
  assign producto = neg_q ? -acc_q : acc_q;

`ifdef MULT_DIV_DIVISION_EN
  logic               es_div_q, es_div_d;
  logic               neg_rem_q, neg_rem_d;
  logic               div_cero_q, div_cero_d;
  logic [ANCHO-1:0]   a_orig_q, a_orig_d;
  logic               resta_ok;
  logic [ANCHO-1:0]   resto_nuevo, cociente, resto;
  logic [2*ANCHO-1:0] paso_div;

  // acc holds {remainder, dividend/quotient}; the shifted-in partial needs ANCHO+1 bits to compare.
  assign resta_ok    = acc_q[2*ANCHO-1:ANCHO-1] >= {1'b0, mag_b_q};
  assign resto_nuevo = acc_q[2*ANCHO-2:ANCHO-1] - mag_b_q;
  assign paso_div    = resta_ok ? {resto_nuevo, acc_q[ANCHO-2:0], 1'b1}
                                : {acc_q[2*ANCHO-2:0], 1'b0};
  assign cociente    = neg_q     ? -acc_q[ANCHO-1:0]       : acc_q[ANCHO-1:0];
  assign resto       = neg_rem_q ? -acc_q[2*ANCHO-1:ANCHO] : acc_q[2*ANCHO-1:ANCHO];
  assign acepta      = bus.inicio;
`else
  assign acepta      = bus.inicio & ~bus.op[1];
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mag_b_d   = mag_b_q;
    neg_d     = neg_q;
    ocupado_d = ocupado_q;
    listo_d   = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;
`ifdef MULT_DIV_DIVISION_EN
    es_div_d   = es_div_q;
    neg_rem_d  = neg_rem_q;
    div_cero_d = div_cero_q;
    a_orig_d   = a_orig_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (acepta) begin
          state_d   = CALC;
          cnt_d     = '0;
          ocupado_d = 1'b1;
          acc_d     = {{ANCHO{1'b0}}, mag_a};
          mag_b_d   = mag_b;
          neg_d     = signo_a ^ signo_b;
`ifdef MULT_DIV_DIVISION_EN
          es_div_d   = bus.op[1];
          neg_rem_d  = signo_a;
          div_cero_d = (bus.operando_b == '0);
          a_orig_d   = bus.operando_a;
`endif
        end
      end
      CALC: begin
        cnt_d = cnt_q + 1'b1;
        acc_d = paso_mul;
`ifdef MULT_DIV_DIVISION_EN
        if (es_div_q) acc_d = paso_div;
`endif
        if (cnt_q == CNT_LAST) begin
          state_d = FIN;
          listo_d = 1'b1;
        end
      end
      FIN: begin
        state_d      = IDLE;
        ocupado_d    = 1'b0;
        {hi_d, lo_d} = producto;
`ifdef MULT_DIV_DIVISION_EN
        if (es_div_q) begin
          if (div_cero_q) begin
            hi_d = a_orig_q;
            lo_d = '1;
          end else begin
            hi_d = resto;
            lo_d = cociente;
          end
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      mag_b_q   <= '0;
      neg_q     <= 1'b0;
      ocupado_q <= 1'b0;
      listo_q   <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
`ifdef MULT_DIV_DIVISION_EN
      es_div_q   <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_cero_q <= 1'b0;
      a_orig_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mag_b_q   <= mag_b_d;
      neg_q     <= neg_d;
      ocupado_q <= ocupado_d;
      listo_q   <= listo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
`ifdef MULT_DIV_DIVISION_EN
      es_div_q   <= es_div_d;
      neg_rem_q  <= neg_rem_d;
      div_cero_q <= div_cero_d;
      a_orig_q   <= a_orig_d;
`endif
    end
  end

  assign bus.ocupado    = ocupado_q;
  assign bus.listo      = listo_q;
  assign bus.hi         = hi_q;
  assign bus.lo         = lo_q;
  assign bus.stall      = ocupado_q & (bus.lee_hilo | bus.inicio);
  assign bus.sel_salida = bus.lee_hilo & ~ocupado_q;
  assign bus.hilo_dato  = bus.sel_hilo ? hi_q : lo_q;
endmodule

// File: tb/tb_control_mult_div.sv
// Randomized bench for control_mult_div: a cycle-count/arithmetic model checked every cycle, plus directed cases.
module tb_control_mult_div;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  control_mult_div_if #(.ANCHO(W)) bus ();
  control_mult_div #(.ANCHO(W), .ITER(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Model: remaining busy cycles and the result the operation will publish.
  int unsigned m_rem = 0;
  logic [31:0] m_hi = '0, m_lo = '0, m_pend_hi = '0, m_pend_lo = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit acepta(input logic [1:0] op);
`ifdef MULT_DIV_DIVISION_EN
    return 1'b1;
`else
    return !op[1];
`endif
  endfunction

  // Returns {HI, LO} computed with plain integer arithmetic.
  function automatic logic [63:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: p = {32'h0, a} * {32'h0, b};
      2'b01: p = sa * sb;
      2'b10: p = (b == 32'h0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
      default: begin
        if (b == 32'h0) p = {a, 32'hFFFFFFFF};
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) p = {32'h0, 32'h80000000};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
    endcase
    return p;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_rem = 0;
      m_hi  = '0;
      m_lo  = '0;
    end else if (m_rem == 0) begin
      if (bus.inicio === 1'b1 && acepta(bus.op)) begin
        {m_pend_hi, m_pend_lo} = ref_res(bus.op, bus.operando_a, bus.operando_b);
        m_rem = 33;
      end
    end else begin
      m_rem--;
      if (m_rem == 0) begin
        m_hi = m_pend_hi;
        m_lo = m_pend_lo;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ocupado", {31'h0, bus.ocupado}, {31'h0, m_rem != 0});
      check("listo", {31'h0, bus.listo}, {31'h0, m_rem == 1});
      check("stall", {31'h0, bus.stall}, {31'h0, (m_rem != 0) && (bus.lee_hilo || bus.inicio)});
      check("sel_salida", {31'h0, bus.sel_salida}, {31'h0, bus.lee_hilo && (m_rem == 0)});
      check("hi", bus.hi, m_hi);
      check("lo", bus.lo, m_lo);
      if (bus.lee_hilo && m_rem == 0)
        check("hilo_dato", bus.hilo_dato, bus.sel_hilo ? m_hi : m_lo);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits up to limit cycles for listo; returns the cycle number it was seen (or limit on timeout).
  task automatic wait_listo(input int start, input int limit, output int cyc);
    cyc = start;
    while (bus.listo !== 1'b1 && cyc < limit) begin
      tick();
      cyc++;
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cyc;
    bus.op = op; bus.operando_a = a; bus.operando_b = b; bus.inicio = 1'b1;
    tick();
    bus.inicio = 1'b0;
    wait_listo(1, 40, cyc);
    check({name, " listo cycle"}, cyc, 33);
    tick();
    check({name, " hi"}, bus.hi, exp_hi);
    check({name, " lo"}, bus.lo, exp_lo);
    check({name, " idle"}, {31'h0, bus.ocupado}, 32'h0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'h1;
      4: return $urandom_range(0, 20);
      5: return -$urandom_range(1, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    int pulses;
    reset = 1'b1;
    bus.inicio = 1'b0; bus.op = 2'b00; bus.operando_a = '0; bus.operando_b = '0;
    bus.lee_hilo = 1'b0; bus.sel_hilo = 1'b0;
    tick(); tick();
    chk_en = 1'b1;
    check("reset ocupado", {31'h0, bus.ocupado}, 32'h0);
    check("reset listo", {31'h0, bus.listo}, 32'h0);
    check("reset hi", bus.hi, 32'h0);
    check("reset lo", bus.lo, 32'h0);
    reset = 1'b0;
    tick();

    // Literal pins on the reference model itself.
    check("model multu", ref_res(2'b00, 32'hFFFFFFFF, 32'h2)[31:0], 32'hFFFFFFFE);
    check("model mult hi", ref_res(2'b01, 32'hFFFFFFFD, 32'h7)[63:32], 32'hFFFFFFFF);
    check("model div lo", ref_res(2'b11, 32'hFFFFFFF9, 32'h2)[31:0], 32'hFFFFFFFD);
    check("model div hi", ref_res(2'b11, 32'hFFFFFFF9, 32'h2)[63:32], 32'hFFFFFFFF);

    run_op("multu", 2'b00, 32'hFFFFFFFF, 32'h2, 32'h1, 32'hFFFFFFFE);
    run_op("mult", 2'b01, 32'hFFFFFFFD, 32'h7, 32'hFFFFFFFF, 32'hFFFFFFEB);
`ifdef MULT_DIV_DIVISION_EN
    run_op("div", 2'b11, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu0", 2'b10, 32'd100, 32'h0, 32'd100, 32'hFFFFFFFF);
    run_op("divovf", 2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
    run_op("divu", 2'b10, 32'd1000, 32'd7, 32'd6, 32'd142);
`endif

    // MFHI arriving mid-operation.
    bus.op = 2'b00; bus.operando_a = 32'd6; bus.operando_b = 32'd7; bus.inicio = 1'b1;
    tick();
    bus.inicio = 1'b0;
    repeat (4) tick();
    bus.lee_hilo = 1'b1; bus.sel_hilo = 1'b1;
    #1;
    check("mfhi stall c5", {31'h0, bus.stall}, 32'h1);
    check("mfhi sel c5", {31'h0, bus.sel_salida}, 32'h0);
    repeat (28) tick();
    check("mfhi stall c33", {31'h0, bus.stall}, 32'h1);
    check("mfhi listo c33", {31'h0, bus.listo}, 32'h1);
    tick();
    check("mfhi sel c34", {31'h0, bus.sel_salida}, 32'h1);
    check("mfhi dato", bus.hilo_dato, 32'h0);
    bus.sel_hilo = 1'b0;
    #1;
    check("mflo dato", bus.hilo_dato, 32'd42);
    tick();
    bus.lee_hilo = 1'b0;
    tick();

    // Back-to-back starts: the second is held from cycle 2.
    bus.op = 2'b00; bus.operando_a = 32'd3; bus.operando_b = 32'd5; bus.inicio = 1'b1;
    tick();
    bus.inicio = 1'b0;
    tick();
    bus.op = 2'b01; bus.operando_a = 32'hFFFFFFFB; bus.operando_b = 32'd9; bus.inicio = 1'b1;
    #1;
    check("b2b stall c2", {31'h0, bus.stall}, 32'h1);
    wait_listo(2, 40, cyc);
    check("b2b first listo", cyc, 33);
    tick();
    check("b2b stall c34", {31'h0, bus.stall}, 32'h0);
    check("b2b lo first", bus.lo, 32'd15);
    tick();
    check("b2b busy c35", {31'h0, bus.ocupado}, 32'h1);
    bus.inicio = 1'b0;
    wait_listo(35, 80, cyc);
    check("b2b second listo", cyc, 67);
    tick();
    check("b2b hi", bus.hi, 32'hFFFFFFFF);
    check("b2b lo", bus.lo, 32'hFFFFFFD3);

    // Reset aborts an operation in flight.
`ifdef MULT_DIV_DIVISION_EN
    bus.op = 2'b11;
`else
    bus.op = 2'b00;
`endif
    bus.operando_a = 32'h12345678; bus.operando_b = 32'd3; bus.inicio = 1'b1;
    tick();
    bus.inicio = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    check("abort ocupado", {31'h0, bus.ocupado}, 32'h0);
    check("abort hi", bus.hi, 32'h0);
    check("abort lo", bus.lo, 32'h0);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.listo === 1'b1) pulses++;
    end
    check("abort no listo", pulses, 0);

`ifndef MULT_DIV_DIVISION_EN
    bus.op = 2'b10; bus.operando_a = 32'd100; bus.operando_b = 32'd0; bus.inicio = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("nodiv ocupado", {31'h0, bus.ocupado}, 32'h0);
      check("nodiv stall", {31'h0, bus.stall}, 32'h0);
    end
    bus.inicio = 1'b0;
    tick();
`endif

    for (int i = 0; i < 3000; i++) begin
      reset        = ($urandom_range(0, 599) == 0);
      bus.inicio   = ($urandom_range(0, 3) == 0);
      bus.op       = 2'($urandom_range(0, 3));
      bus.operando_a = pick();
      bus.operando_b = pick();
      bus.lee_hilo = $urandom_range(0, 1) == 1;
      bus.sel_hilo = $urandom_range(0, 1) == 1;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
